// File: rtl/psum_arb_pkg.sv
// psum_arb_pkg: shared types and requester indices for the partial-sum memory arbiter
package psum_arb_pkg;
    typedef enum logic {INIT, READY} state_t;
    localparam int NUM_REQ = 2;
    localparam int REQ_CORE = 0;
    localparam int REQ_HOST = 1;
endpackage

// File: rtl/psum_mem_arbiter_if.sv
// psum_mem_arbiter_if: requester handshakes plus the pseudo-2-port memory pins
interface psum_mem_arbiter_if
    import psum_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = $clog2(HEIGHT)
) ();
    logic [NUM_REQ-1:0]        rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr, wr_addr;
    logic [NUM_REQ*WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]          rd_data, mem_qout, mem_din;
    logic [ADDR_W-1:0]         mem_read_addr, mem_write_addr;
    logic                      mem_read_en, mem_write_en;
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_qout,
        input  rd_gnt, rd_data, rd_valid, wr_gnt,
        input  mem_read_addr, mem_read_en, mem_write_addr, mem_din, mem_write_en
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_qout,
        output rd_gnt, rd_data, rd_valid, wr_gnt,
        output mem_read_addr, mem_read_en, mem_write_addr, mem_din, mem_write_en
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, pointer names the preferred requester
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;
    always_comb gnt = !en ? 2'b00 : (&req ? (ptr ? 2'b10 : 2'b01) : req);
    always_ff @(posedge clk)
        if (rst) ptr <= 1'b0;
        else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/psum_mem_arbiter.sv
// psum_mem_arbiter: zero-fills and shares the partial-sum memory between core and host
module psum_mem_arbiter
    import psum_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 256,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               clear_req,
    output logic               init_done,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   wr_count,
    psum_mem_arbiter_if.slave  bus
);
    localparam int ADDR_W = $clog2(HEIGHT);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              en, init_w, byp;
    logic [WIDTH-1:0]  byp_data;
    always_ff @(posedge clk)
        if (rst_in) state <= INIT;
        else state <= state_nx;
    always_comb
        state_nx = (state == INIT) ? ((cnt == ADDR_W'(HEIGHT - 1)) ? READY : INIT)
                                   : (clear_req ? INIT : READY);
    // grants and init writes are both masked in the reset cycle itself
    always_comb begin
        init_done = (state == READY);
        en        = init_done && !rst_in;
        init_w    = (state == INIT) && !rst_in;
    end
    rr_arbiter2 u_rd_arb (.clk(clk), .rst(rst_in), .en(en), .req(bus.rd_req), .gnt(bus.rd_gnt));
    rr_arbiter2 u_wr_arb (.clk(clk), .rst(rst_in), .en(en), .req(bus.wr_req), .gnt(bus.wr_gnt));
    always_comb begin
        bus.mem_read_en    = |bus.rd_gnt;
        bus.mem_read_addr  = bus.rd_gnt[REQ_HOST] ? bus.rd_addr[REQ_HOST*ADDR_W +: ADDR_W]
                                                  : bus.rd_addr[REQ_CORE*ADDR_W +: ADDR_W];
        bus.mem_write_en   = init_w || (|bus.wr_gnt);
        bus.mem_write_addr = init_w ? cnt
                           : (bus.wr_gnt[REQ_HOST] ? bus.wr_addr[REQ_HOST*ADDR_W +: ADDR_W]
                                                   : bus.wr_addr[REQ_CORE*ADDR_W +: ADDR_W]);
        bus.mem_din        = init_w ? '0
                           : (bus.wr_gnt[REQ_HOST] ? bus.wr_data[REQ_HOST*WIDTH +: WIDTH]
                                                   : bus.wr_data[REQ_CORE*WIDTH +: WIDTH]);
        bus.rd_data        = byp ? byp_data : bus.mem_qout;
    end
    always_ff @(posedge clk)
        if (rst_in) begin
            cnt          <= '0;
            bus.rd_valid <= '0;
            byp          <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            cnt          <= (state == INIT) ? cnt + 1'b1 : '0;
            bus.rd_valid <= bus.rd_gnt;
            byp          <= (|bus.rd_gnt) && (|bus.wr_gnt) && (bus.mem_read_addr == bus.mem_write_addr);
            rd_count     <= rd_count + CNT_W'(|bus.rd_gnt);
            wr_count     <= wr_count + CNT_W'(|bus.wr_gnt);
        end
    // write-first bypass data: the memory itself returns the old word on a same-address collision
    always_ff @(posedge clk) byp_data <= bus.mem_din;
endmodule

// File: tb/tb_psum_mem_arbiter.sv
// tb_psum_mem_arbiter: randomized scoreboard bench against a queue/array reference model
module tb_psum_mem_arbiter;
    localparam int H = 256;
    typedef struct {logic [1:0] v; logic [31:0] d;} exp_t;
    logic clk = 1'b0;
    logic rst_in = 1'b1, clear_req = 1'b0, init_done;
    logic [31:0] rd_count, wr_count;
    logic [31:0] mem [H];
    logic [31:0] ref_mem [H];
    exp_t sbq[$];
    int checks = 0, errors = 0;
    bit m_ready = 1'b0;
    int m_left = H, ptr_r = 0, ptr_w = 0;
    logic [31:0] m_rc = 0, m_wc = 0;
    always #5 clk = ~clk;
    psum_mem_arbiter_if #(.WIDTH(32), .HEIGHT(H)) bus ();
    psum_mem_arbiter #(.WIDTH(32), .HEIGHT(H), .CNT_W(32)) dut (
        .clk(clk), .rst_in(rst_in), .clear_req(clear_req), .init_done(init_done),
        .rd_count(rd_count), .wr_count(wr_count), .bus(bus)
    );
    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_qout <= mem[bus.mem_read_addr];
        if (bus.mem_write_en) mem[bus.mem_write_addr] <= bus.mem_din;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int arb(input logic [1:0] req, input int ptr);
        if (req == 2'b00) return -1;
        if (req == 2'b11) return ptr;
        return req[1] ? 1 : 0;
    endfunction
    task automatic step(input logic rst, input logic clr, input logic [1:0] rq, input logic [1:0] wq,
                        input logic [7:0] ra0, input logic [7:0] ra1, input logic [7:0] wa0,
                        input logic [7:0] wa1, input logic [31:0] wd0, input logic [31:0] wd1);
        logic [7:0] ra [2];
        logic [7:0] wa [2];
        logic [31:0] wd [2];
        int gr, gw;
        ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
        @(posedge clk); #1;
        rst_in = rst; clear_req = clr;
        bus.rd_req = rq; bus.rd_addr = {ra1, ra0};
        bus.wr_req = wq; bus.wr_addr = {wa1, wa0}; bus.wr_data = {wd1, wd0};
        @(negedge clk);
        if (rst) begin
            chk("rst_rd_gnt", {30'd0, bus.rd_gnt}, 0);
            chk("rst_wr_gnt", {30'd0, bus.wr_gnt}, 0);
            chk("rst_mem_write_en", {31'd0, bus.mem_write_en}, 0);
            m_ready = 1'b0; m_left = H; ptr_r = 0; ptr_w = 0; m_rc = 0; m_wc = 0;
            return;
        end
        chk("init_done", {31'd0, init_done}, {31'd0, m_ready});
        chk("rd_count", rd_count, m_rc);
        chk("wr_count", wr_count, m_wc);
        if (!m_ready) begin
            chk("init_rd_gnt", {30'd0, bus.rd_gnt}, 0);
            chk("init_wr_gnt", {30'd0, bus.wr_gnt}, 0);
            chk("init_read_en", {31'd0, bus.mem_read_en}, 0);
            chk("init_write_en", {31'd0, bus.mem_write_en}, 1);
            chk("init_write_addr", {24'd0, bus.mem_write_addr}, H - m_left);
            chk("init_din", bus.mem_din, 0);
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                foreach (ref_mem[i]) ref_mem[i] = 0;
            end
            return;
        end
        gr = arb(rq, ptr_r);
        gw = arb(wq, ptr_w);
        chk("rd_gnt", {30'd0, bus.rd_gnt}, gr < 0 ? 0 : (gr == 1 ? 2 : 1));
        chk("wr_gnt", {30'd0, bus.wr_gnt}, gw < 0 ? 0 : (gw == 1 ? 2 : 1));
        if (gr >= 0) begin
            chk("mem_read_addr", {24'd0, bus.mem_read_addr}, {24'd0, ra[gr]});
            sbq.push_back('{gr == 1 ? 2'b10 : 2'b01,
                            (gw >= 0 && wa[gw] == ra[gr]) ? wd[gw] : ref_mem[ra[gr]]});
            ptr_r = 1 - gr;
            m_rc++;
        end
        if (gw >= 0) begin
            chk("mem_write_addr", {24'd0, bus.mem_write_addr}, {24'd0, wa[gw]});
            chk("mem_din", bus.mem_din, wd[gw]);
            ref_mem[wa[gw]] = wd[gw];
            ptr_w = 1 - gw;
            m_wc++;
        end
        if (clr) begin
            m_ready = 1'b0;
            m_left = H;
        end
    endtask
    task automatic idle(input int n);
        repeat (n) step(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #2;
            e = sbq.size() != 0 ? sbq.pop_front() : '{2'b00, 32'd0};
            chk("rd_valid", {30'd0, bus.rd_valid}, {30'd0, e.v});
            if (e.v != 2'b00) chk("rd_data", bus.rd_data, e.d);
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        bus.rd_req = 0; bus.rd_addr = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
        step(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(H);
        step(0, 0, 2'b01, 2'b00, 17, 0, 0, 0, 0, 0);
        step(0, 0, 2'b00, 2'b01, 0, 0, 5, 0, 32'hDEADBEEF, 0);
        step(0, 0, 2'b10, 2'b00, 0, 5, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(H);
        repeat (4) step(0, 0, 2'b11, 2'b00, 1, 2, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 2'b01, 2'b10, 9, 0, 0, 9, 0, 32'h12345678);
        step(0, 0, 2'b10, 2'b00, 0, 9, 0, 0, 0, 0);
        step(0, 0, 2'b00, 2'b01, 0, 0, 3, 0, 32'hAA, 0);
        step(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(H);
        step(0, 0, 2'b01, 2'b00, 3, 0, 0, 0, 0, 0);
        step(0, 0, 2'b10, 2'b00, 0, 7, 0, 0, 0, 0);
        step(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(H);
        repeat (800)
            step(0, $urandom_range(0, 299) == 0, 2'($urandom), 2'($urandom),
                 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), $urandom, $urandom);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_mem_arbiter.md
Name: psum_mem_arbiter

Overview:
- Owns the on-chip pseudo-2-port partial-sum memory (one read port, one write port) and shares it between two requesters: requester 0 is the core accumulator datapath and requester 1 is the host/drain readout.
- After reset, and on request, it zero-fills the memory.
- It counts granted read and write accesses for bandwidth reporting.
- It sits between top_chip's partial-sum interface and the memory instance.

Parameters:
- WIDTH, 32, memory word width (matches ACCUMULATION_WIDTH).
- HEIGHT, 256, memory depth in words; must be a power of two and at least 2.
- ADDR_W, $clog2(HEIGHT), derived address width; not overridden.
- CNT_W, 32, width of the access counters.

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous reset, active-high
- clear_req  in  1  pulse: re-zero the whole memory
- init_done  out  1  high when READY (memory zeroed, grants enabled)
- rd_req  in  2  per-requester read request
- rd_addr  in  2*ADDR_W  per-requester read address (requester r at bits [r*ADDR_W +: ADDR_W])
- rd_gnt  out  2  one-hot read grant, combinational
- rd_data  out  WIDTH  read data, shared bus
- rd_valid  out  2  one-hot: rd_data valid for that requester
- wr_req  in  2  per-requester write request
- wr_addr  in  2*ADDR_W  per-requester write address
- wr_data  in  2*WIDTH  per-requester write data
- wr_gnt  out  2  one-hot write grant, combinational
- mem_read_addr  out  ADDR_W  memory read address
- mem_read_en  out  1  memory read enable
- mem_qout  in  WIDTH  memory data, valid 1 cycle after mem_read_en
- mem_write_addr  out  ADDR_W  memory write address
- mem_din  out  WIDTH  memory write data
- mem_write_en  out  1  memory write enable
- rd_count  out  CNT_W  granted reads since reset
- wr_count  out  CNT_W  granted writes since reset (excludes init writes)

Behaviour:
- State machine has two states, INIT and READY.
  - Reset enters INIT with init counter = 0.
  - INIT: mem_write_en=1, mem_write_addr=counter, mem_din=0, counter +1 per cycle. After writing address HEIGHT-1, go to READY. INIT always lasts exactly HEIGHT cycles.
  - READY: init_done=1. clear_req=1 goes to INIT next cycle with counter=0; that cycle's grants still proceed normally.
  - clear_req during INIT is ignored.
- During INIT, rd_gnt=wr_gnt=0 and mem_read_en=0.
- Reset values: init_done=0, rd_gnt=0, wr_gnt=0, rd_valid=0, rd_count=0, wr_count=0, mem_read_en=0, both round-robin pointers select requester 0. In the reset cycle itself (rst_in high), mem_write_en=0.
- Read arbitration (READY):
  - 2-way round-robin. The pointer names the preferred requester.
  - If only one requester asserts rd_req, it is granted. If both assert, the preferred one is granted.
  - After a grant, the pointer moves to the other requester. With no grant, the pointer holds.
- Write arbitration: identical rule, independent pointer. Reads and writes can both be granted in the same cycle.
- Requester obligation: hold req, addr and data stable until its gnt is seen. gnt is combinational, and the transfer happens in the cycle where req and gnt are both high.
- Memory mapping:
  - mem_read_en = |rd_gnt; mem_read_addr = address of the granted requester.
  - mem_write_en = |wr_gnt (or INIT); mem_write_addr and mem_din are taken from the granted writer.
- Read latency is 1 cycle. rd_valid = rd_gnt registered. rd_data = mem_qout in that cycle, unless bypass applies.
- Bypass (write-first): a read and a write granted in the same cycle to the same address return that write's data on rd_data next cycle. The registered bypass flag and registered data select it.
- Back-to-back reads are fully pipelined, one per cycle.
- Counters increment by popcount of the grant vector (0 or 1). They wrap modulo 2^CNT_W and are not cleared by clear_req.
- Reset mid-operation: pending rd_valid is dropped next cycle, pointers and counters reset, INIT restarts.
- Memory contents are not otherwise touched until INIT rewrites them.

Decomposition:
- Shared package psum_arb_pkg holds:
  - state typedef enum {INIT, READY};
  - NUM_REQ=2;
  - REQ_CORE=0 and REQ_HOST=1.
- Natural sub-module: rr_arbiter2, a 2-input round-robin arbiter (req[1:0], pointer register, one-hot gnt). It is instantiated twice, once for reads and once for writes.

Test Plan:
- Reset with HEIGHT=256: init_done goes high exactly 256 cycles after rst_in falls; each address 0..255 is written with 0; no grants during INIT; reading address 17 afterwards returns 0.
- Core writes 0xDEADBEEF to address 5, then the host reads address 5 the next cycle: rd_gnt=2'b10; one cycle later rd_valid=2'b10 and rd_data=0xDEADBEEF.
- Both requesters hold rd_req for 4 cycles starting from reset pointers: grants alternate 01,10,01,10; rd_count=4.
- Same-cycle read and write to address 9, write data 0x12345678: next cycle rd_data=0x12345678 (bypass); a read of address 9 one cycle later also returns 0x12345678.
- clear_req in READY after writing 0xAA to address 3: init_done drops for 256 cycles, then a read of address 3 returns 0; wr_count is unchanged by the INIT writes.
- Assert rst_in for one cycle while the host read granted the previous cycle is in flight: rd_valid=0 the next cycle, counters read 0, INIT restarts.
